// File: rtl/secdec_awe_pkg.sv
// Shared constants and state encoding for the AN-code (A = 67) single-error
// correcting decoder.
package secdec_awe_pkg;

  localparam int W_BITS = 32;
  localparam int N_BITS = 25;
  localparam int A      = 67;
  localparam int R_BITS = 7;

  // A at the widths used by the residue arithmetic (residue and residue+1 bit)
  localparam logic [R_BITS-1:0] A_RES = R_BITS'(A);
  localparam logic [R_BITS:0]   A_EXT = (R_BITS + 1)'(A);

  typedef enum logic [2:0] {
    IDLE,
    DIV1,
    CHECK,
    SEARCH,
    DIV2,
    DONE
  } state_e;

endpackage

// File: rtl/an_const_divider.sv
// Restoring divider by the constant A, one quotient bit per cycle, MSB first.
// The start cycle already consumes the first dividend bit, so 32 cycles total.
module an_const_divider
  import secdec_awe_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [W_BITS-1:0]   dividend_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [W_BITS-1:0]   quotient_o,
  output logic [R_BITS-1:0]   remainder_o
);

  logic [W_BITS-1:0] sh_q, sh_d;
  logic [R_BITS-1:0] rem_q, rem_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              done_q, done_d;

  logic [W_BITS-1:0] src;
  logic [R_BITS-1:0] rem_src;
  logic [R_BITS:0]   trial;
  logic              qbit;
  logic [R_BITS-1:0] rem_new;
  logic              step;

  // sh holds the not-yet-consumed dividend bits above the quotient bits produced so far
  always_comb begin
    src     = start_i ? dividend_i : sh_q;
    rem_src = start_i ? '0 : rem_q;
    trial   = {rem_src, src[W_BITS-1]};
    qbit    = (trial >= A_EXT);
    rem_new = qbit ? R_BITS'(trial - A_EXT) : trial[R_BITS-1:0];
    step    = start_i || (cnt_q != 6'd0);

    sh_d   = sh_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (step) begin
      sh_d  = {src[W_BITS-2:0], qbit};
      rem_d = rem_new;
      if (start_i) begin
        cnt_d = 6'(W_BITS - 1);
      end else begin
        cnt_d  = cnt_q - 6'd1;
        done_d = (cnt_q == 6'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q   <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign busy_o      = (cnt_q != 6'd0);
  assign done_o      = done_q;
  assign quotient_o  = sh_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/secdecoder_awe_24bits_clk.sv
// Sequential single-error-correcting AN-code decoder (A = 67): divides, and on a
// nonzero residue searches for the +/-2^i error that explains it, then re-divides.
module secdecoder_awe_24bits_clk
  import secdec_awe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_BITS-1:0] W,
  output logic              found,
  output logic [N_BITS-1:0] N
);

  state_e            state_q, state_d;
  logic [W_BITS-1:0] w_q, w_d;
  logic [W_BITS-1:0] c_q, c_d;
  logic [N_BITS-1:0] n_q, n_d;
  logic [R_BITS-1:0] r_q, r_d;
  logic [R_BITS-1:0] p_q, p_d;
  logic [4:0]        i_q, i_d;
  logic              done_q, done_d;

  logic              restart;
  logic [W_BITS:0]   pow;
  logic [W_BITS:0]   sum_plus;
  logic              minus_ok;
  logic              plus_ok;
  logic [R_BITS:0]   dbl;

  logic              div_start;
  logic [W_BITS-1:0] div_dividend;
  logic              div_busy;
  logic              div_done;
  logic [W_BITS-1:0] div_quot;
  logic [R_BITS-1:0] div_rem;
  logic              unused_quot_hi;

  an_const_divider u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_start),
    .dividend_i  (div_dividend),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quot),
    .remainder_o (div_rem)
  );

  // Valid payloads fit in N_BITS; the upper quotient bits carry no information.
  assign unused_quot_hi = ^div_quot[W_BITS-1:N_BITS];

  always_comb begin
    restart  = (state_q == IDLE) || (W != w_q);
    pow      = (W_BITS + 1)'(1) << i_q;
    sum_plus = {1'b0, w_q} + pow;
    minus_ok = (p_q == r_q) && ({1'b0, w_q} >= pow);
    plus_ok  = ((A_RES - p_q) == r_q) && !sum_plus[W_BITS];
    dbl      = {p_q, 1'b0};

    // DIV1 starts on the restart edge straight from W; DIV2 starts from C once idle
    div_start    = restart || ((state_q == DIV2) && !div_busy && !div_done);
    div_dividend = restart ? W : c_q;

    state_d = state_q;
    w_d     = w_q;
    c_d     = c_q;
    n_d     = n_q;
    r_d     = r_q;
    p_d     = p_q;
    i_d     = i_q;
    done_d  = done_q;

    if (restart) begin
      w_d     = W;
      done_d  = 1'b0;
      state_d = DIV1;
    end else begin
      case (state_q)
        DIV1: begin
          if (div_done) begin
            r_d     = div_rem;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (r_q == '0) begin
            n_d     = div_quot[N_BITS-1:0];
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            i_d     = '0;
            p_d     = R_BITS'(1);
            state_d = SEARCH;
          end
        end
        SEARCH: begin
          if (minus_ok) begin
            c_d     = w_q - pow[W_BITS-1:0];
            state_d = DIV2;
          end else if (plus_ok) begin
            c_d     = sum_plus[W_BITS-1:0];
            state_d = DIV2;
          end else if (i_q == 5'd31) begin
            n_d     = div_quot[N_BITS-1:0];
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            i_d = i_q + 5'd1;
            p_d = (dbl >= A_EXT) ? R_BITS'(dbl - A_EXT) : dbl[R_BITS-1:0];
          end
        end
        DIV2: begin
          if (div_done) begin
            n_d     = div_quot[N_BITS-1:0];
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      c_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
      i_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      c_q     <= c_d;
      n_q     <= n_d;
      r_q     <= r_d;
      p_q     <= p_d;
      i_q     <= i_d;
      done_q  <= done_d;
    end
  end

  // Combinational so a new W hides the old result in the very same cycle
  assign found = done_q && (W == w_q);
  assign N     = n_q;

endmodule

// File: tb/tb_secdecoder_awe_24bits_clk.sv
// Randomized self-checking bench: each decode is compared against a brute-force
// arithmetic model of the AN code (payload and exact latency).
module tb_secdecoder_awe_24bits_clk;

  logic        clk;
  logic        rst_n;
  logic [31:0] w_in;
  logic        found;
  logic [24:0] n_out;

  int tests_run;
  int tests_failed;

  secdecoder_awe_24bits_clk dut (
    .clk   (clk),
    .rst_n (rst_n),
    .W     (w_in),
    .found (found),
    .N     (n_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Smallest-i search over all +/-2^i corrections, minus before plus at equal i.
  function automatic void model(input logic [31:0] w, output logic [24:0] n_exp,
                                output int lat_exp);
    longint wl;
    longint pw;
    longint lim;
    wl  = longint'(w);
    lim = longint'(1) << 32;
    if (wl % 67 == 0) begin
      n_exp   = 25'(wl / 67);
      lat_exp = 34;
      return;
    end
    for (int i = 0; i < 32; i++) begin
      pw = longint'(1) << i;
      if (wl >= pw && (wl - pw) % 67 == 0) begin
        n_exp   = 25'((wl - pw) / 67);
        lat_exp = 34 + (i + 1) + 32 + 1;
        return;
      end
      if (wl + pw < lim && (wl + pw) % 67 == 0) begin
        n_exp   = 25'((wl + pw) / 67);
        lat_exp = 34 + (i + 1) + 32 + 1;
        return;
      end
    end
    n_exp   = 25'(wl / 67);
    lat_exp = 34 + 32;
  endfunction

  // Drives W (called away from the clock edge) and counts edges until found.
  task automatic decode(input logic [31:0] w, input string tag);
    logic [24:0] n_exp;
    int          lat_exp;
    int          lat;
    bit          seen;
    model(w, n_exp, lat_exp);
    w_in = w;
    lat  = 0;
    seen = 1'b0;
    while (lat < 200 && !seen) begin
      @(posedge clk);
      #1;
      lat++;
      if (found) seen = 1'b1;
    end
    check_val({tag, "_found"}, 32'(seen), 32'd1);
    check_val({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    check_val({tag, "_N"}, 32'(n_out), 32'(n_exp));
    $display("[TB] %s W=%0d N=%0d exp=%0d lat=%0d exp_lat=%0d", tag, w, n_out, n_exp,
             lat, lat_exp);
  endtask

  // Starts a decode of w1, abandons it after k cycles, then decodes w2.
  task automatic interrupt(input logic [31:0] w1, input int k, input logic [31:0] w2,
                           input string tag);
    bit early;
    early = 1'b0;
    w_in  = w1;
    for (int c = 0; c < k; c++) begin
      @(posedge clk);
      #1;
      if (found) early = 1'b1;
    end
    check_val({tag, "_no_early_found"}, 32'(early), 32'd0);
    decode(w2, tag);
  endtask

  function automatic logic [31:0] make_word(input int unsigned n, input int mode, input int i);
    longint cw;
    cw = longint'(n) * 67;
    if (mode == 1) cw = cw + (longint'(1) << i);
    if (mode == 2) cw = cw - (longint'(1) << i);
    if (cw < 0 || cw >= (longint'(1) << 32)) cw = longint'(n) * 67;
    return 32'(cw);
  endfunction

  initial begin
    logic [31:0] w_tmp;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    w_in         = '0;

    repeat (3) @(posedge clk);
    #1;
    check_val("reset_N", 32'(n_out), 32'd0);
    check_val("reset_found", 32'(found), 32'd0);
    rst_n = 1'b1;

    decode(32'd1124073405, "clean_max");
    decode(32'd1124073406, "plus_2p0");
    decode(32'd1124073404, "minus_2p0");
    decode(32'd3271557053, "plus_2p31");
    decode(32'd1123024829, "minus_2p20");
    decode(32'd0, "zero");

    // found must fall in the same cycle W moves away from the decoded word
    decode(32'd1124073405, "pre_drop");
    w_in = 32'd670;
    #1;
    check_val("found_drop", 32'(found), 32'd0);
    decode(32'd670, "post_drop");

    for (int i = 0; i < 32; i++) begin
      decode(make_word(32'd16777215, 1, i), $sformatf("sweep_plus_%0d", i));
      if (i < 31) decode(make_word(32'd16777215, 2, i), $sformatf("sweep_minus_%0d", i));
    end

    interrupt(32'd1123024829, 5, make_word($urandom_range(0, 16777215), 0, 0), "intr_div1");
    interrupt(32'd1123024829, 40, make_word($urandom_range(0, 16777215), 1, 7), "intr_search");
    interrupt(32'd1123024829, 60, make_word($urandom_range(0, 16777215), 2, 3), "intr_div2");

    // Reset in the middle of a decode clears N and restarts on release
    w_in = 32'd1124073405 + 32'd8;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("midreset_N", 32'(n_out), 32'd0);
    check_val("midreset_found", 32'(found), 32'd0);
    rst_n = 1'b1;
    decode(32'd1124073413, "after_reset");

    for (int t = 0; t < 60; t++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      if (mode == 3) begin
        w_tmp = $urandom;
      end else begin
        w_tmp = make_word($urandom_range(0, 16777215), mode, int'($urandom_range(0, 31)));
      end
      decode(w_tmp, $sformatf("rand_%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
